// File: rtl/cam_capture_stream.sv
// cam_capture_stream: oversampling camera capture front end.
// Synchronises a parallel camera bus (xclk/vsync/href/data) into the system
// clock domain, packs PACK bytes per output word, tags frame start and line
// end, and delivers words through a small FIFO with a valid/ready handshake.
// Status: line counter, frame-done pulse, sticky overflow and misalign flags.

module cam_capture_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK       = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 11
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cam_xclk,
    input  logic                       cam_vsync,
    input  logic                       cam_href,
    input  logic [DATA_WIDTH-1:0]      cam_dat,
    input  logic                       enable,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic                       m_sof,
    output logic                       m_eol,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CNT_WIDTH-1:0]       line_count,
    output logic                       frame_done,
    output logic                       overflow,
    output logic                       misalign,
    input  logic                       clear_status
);

    localparam int unsigned WORD_W = DATA_WIDTH * PACK;
    localparam int unsigned IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTF_W = PTR_W + 1;
    localparam int unsigned ENT_W  = WORD_W + 2;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_CAPTURE    = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronisers and edge-detect registers
    // ------------------------------------------------------------------
    logic [1:0]            xclk_sync;
    logic [1:0]            vsync_sync;
    logic [1:0]            href_sync;
    logic [DATA_WIDTH-1:0] dat_s1;
    logic [DATA_WIDTH-1:0] dat_s;
    logic                  xclk_d;
    logic                  vsync_d;
    logic                  href_d;

    logic xclk_s;
    logic vsync_s;
    logic href_s;
    logic xclk_rise;
    logic vsync_rise;
    logic vsync_fall;
    logic href_fall;

    // Two-flop synchronisers followed by one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (!resetn) begin
            xclk_sync  <= '0;
            vsync_sync <= '0;
            href_sync  <= '0;
            dat_s1     <= '0;
            dat_s      <= '0;
            xclk_d     <= 1'b0;
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
        end else begin
            xclk_sync  <= {xclk_sync[0], cam_xclk};
            vsync_sync <= {vsync_sync[0], cam_vsync};
            href_sync  <= {href_sync[0], cam_href};
            dat_s1     <= cam_dat;
            dat_s      <= dat_s1;
            xclk_d     <= xclk_sync[1];
            vsync_d    <= vsync_sync[1];
            href_d     <= href_sync[1];
        end
    end

    assign xclk_s     = xclk_sync[1];
    assign vsync_s    = vsync_sync[1];
    assign href_s     = href_sync[1];
    assign xclk_rise  = xclk_s & ~xclk_d;
    assign vsync_rise = vsync_s & ~vsync_d;
    assign vsync_fall = ~vsync_s & vsync_d;
    assign href_fall  = ~href_s & href_d;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_next;
    logic       enter_capture;
    logic       frame_end;
    logic       in_capture;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and frame event decode
    always_comb begin
        state_next    = state;
        enter_capture = 1'b0;
        frame_end     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (vsync_fall) begin
                    state_next    = ST_CAPTURE;
                    enter_capture = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (vsync_rise) begin
                    frame_end  = 1'b1;
                    state_next = enable ? ST_WAIT_FRAME : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_capture = (state == ST_CAPTURE);

    // ------------------------------------------------------------------
    // Byte packer and one-entry pending word
    // ------------------------------------------------------------------
    logic              byte_strobe;
    logic              line_end;
    logic [WORD_W-1:0] packer;
    logic [IDX_W-1:0]  byte_idx;
    logic              word_done;
    logic [WORD_W-1:0] pend_data;
    logic              pend_valid;
    logic              sof_flag;

    logic              push;
    logic              push_eol;
    logic [ENT_W-1:0]  push_entry;

    assign byte_strobe = in_capture & xclk_rise & href_s;
    assign line_end    = in_capture & href_fall;

    // Push request towards the FIFO: a completed word displaces the pending
    // one (not line end), or the line end flushes the pending word with eol.
    // The clk/xclk ratio keeps word completion and line end in separate cycles.
    always_comb begin
        push     = 1'b0;
        push_eol = 1'b0;
        if (word_done && pend_valid) begin
            push = 1'b1;
        end else if (line_end && pend_valid) begin
            push     = 1'b1;
            push_eol = 1'b1;
        end
        push_entry = {sof_flag, push_eol, pend_data};
    end

    // Shift bytes in MSB-first so the first byte ends in the LSBs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            packer     <= '0;
            byte_idx   <= '0;
            word_done  <= 1'b0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            sof_flag   <= 1'b0;
        end else if (enter_capture) begin
            byte_idx   <= '0;
            word_done  <= 1'b0;
            pend_valid <= 1'b0;
            sof_flag   <= 1'b1;
        end else begin
            word_done <= 1'b0;
            if (byte_strobe) begin
                packer <= WORD_W'({dat_s, packer} >> DATA_WIDTH);
                if (byte_idx == IDX_W'(PACK - 1)) begin
                    byte_idx  <= '0;
                    word_done <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end else if (line_end) begin
                // Partial bytes are abandoned; the shift register refills them
                byte_idx <= '0;
            end

            if (word_done) begin
                pend_data  <= packer;
                pend_valid <= 1'b1;
            end else if (push) begin
                pend_valid <= 1'b0;
            end

            if (push) begin
                sof_flag <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line counter, frame pulse and sticky status
    // ------------------------------------------------------------------
    logic misalign_set;
    logic overflow_set;

    assign misalign_set = line_end & (byte_idx != '0);

    // Line counting and frame-done pulse
    always_ff @(posedge clk) begin
        if (!resetn) begin
            line_count <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (enter_capture) begin
                line_count <= '0;
            end else if (line_end && (line_count != {CNT_WIDTH{1'b1}})) begin
                line_count <= line_count + CNT_WIDTH'(1);
            end
        end
    end

    // Sticky flags; a set in the same cycle as a clear takes precedence
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow <= 1'b0;
            misalign <= 1'b0;
        end else begin
            overflow <= overflow_set | (overflow & ~clear_status);
            misalign <= misalign_set | (misalign & ~clear_status);
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO with registered head
    // ------------------------------------------------------------------
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNTF_W-1:0] fifo_count;

    logic              pop;
    logic              push_ok;
    logic [CNTF_W-1:0] count_next;
    logic [CNTF_W-1:0] count_after_pop;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [ENT_W-1:0]  head_next;

    // Handshake, acceptance and next head-of-queue selection
    always_comb begin
        pop          = m_valid & m_ready;
        push_ok      = push & ((fifo_count < CNTF_W'(FIFO_DEPTH)) | pop);
        overflow_set = push & ~push_ok;

        count_next = fifo_count;
        if (push_ok && !pop) begin
            count_next = fifo_count + CNTF_W'(1);
        end else if (!push_ok && pop) begin
            count_next = fifo_count - CNTF_W'(1);
        end

        count_after_pop = pop ? (fifo_count - CNTF_W'(1)) : fifo_count;
        rd_ptr_next     = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;

        if (count_next == '0) begin
            head_next = '0;
        end else if (count_after_pop == '0) begin
            head_next = push_entry;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // FIFO storage; contents are don't-care while the count is zero
    always_ff @(posedge clk) begin
        if (resetn && push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers, occupancy and registered stream outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_sof      <= 1'b0;
            m_eol      <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_ptr_next;
            fifo_count <= count_next;
            m_valid    <= (count_next != '0);
            m_data     <= head_next[WORD_W-1:0];
            m_eol      <= head_next[WORD_W];
            m_sof      <= head_next[WORD_W+1];
        end
    end

endmodule

// File: tb/tb_cam_capture_stream.sv
// Testbench for cam_capture_stream: drives a camera bus at 1/8 of clk,
// collects output words and compares them against a frame-level model.

module tb_cam_capture_stream;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eol;
    } word_t;

    typedef struct {
        int nlines;
        int len;
        int base;
        int exp_words;
        bit exp_mis;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        cam_xclk;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_dat;
    logic        enable;
    logic [31:0] m_data;
    logic        m_sof;
    logic        m_eol;
    logic        m_valid;
    logic        m_ready;
    logic [10:0] line_count;
    logic        frame_done;
    logic        overflow;
    logic        misalign;
    logic        clear_status;

    logic ready_ctl;
    logic rand_mode;
    logic rnd_bit;

    int tests;
    int fails;
    int fd_count;
    int fd_lines;
    int valid_cycles;

    word_t rx_q[$];
    word_t exp_q[$];
    bit    exp_mis;

    int         line_len [4];
    logic [7:0] line_byte [4][64];

    logic  have_prev;
    logic  prev_valid;
    logic  prev_ready;
    word_t prev_word;

    cam_capture_stream #(
        .DATA_WIDTH(8),
        .PACK(4),
        .FIFO_DEPTH(4),
        .CNT_WIDTH(11)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .cam_xclk(cam_xclk),
        .cam_vsync(cam_vsync),
        .cam_href(cam_href),
        .cam_dat(cam_dat),
        .enable(enable),
        .m_data(m_data),
        .m_sof(m_sof),
        .m_eol(m_eol),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .line_count(line_count),
        .frame_done(frame_done),
        .overflow(overflow),
        .misalign(misalign),
        .clear_status(clear_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_ready = rand_mode ? rnd_bit : ready_ctl;

    always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled just after the falling edge, away from the active edge
    always @(negedge clk) begin
        #1;
        if (!resetn) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev && prev_valid && !prev_ready) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_word", 64'({m_data, m_sof, m_eol}), 64'(prev_word));
            end
            if (m_valid && m_ready) rx_q.push_back('{data: m_data, sof: m_sof, eol: m_eol});
            if (frame_done) begin
                fd_count++;
                fd_lines = int'(line_count);
            end
            if (m_valid) valid_cycles++;
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_word  = '{data: m_data, sof: m_sof, eol: m_eol};
            have_prev  = 1'b1;
        end
    end

    // Frame-level reference: whole words per line, eol on the last whole
    // word of each line, sof on the first word of the frame
    function automatic void model_frame(input int nlines);
        logic  first;
        word_t w;
        int    nw;
        exp_q.delete();
        exp_mis = 1'b0;
        first   = 1'b1;
        for (int l = 0; l < nlines; l++) begin
            nw = line_len[l] / 4;
            if ((line_len[l] % 4) != 0) exp_mis = 1'b1;
            for (int k = 0; k < nw; k++) begin
                w.data = 32'd0;
                for (int b = 0; b < 4; b++) w.data = w.data | (32'(line_byte[l][4*k+b]) << (8 * b));
                w.sof = first;
                w.eol = (k == nw - 1);
                first = 1'b0;
                exp_q.push_back(w);
            end
        end
    endfunction

    function automatic void fill_lines(input int nlines, input int len, input int base);
        for (int l = 0; l < nlines; l++) begin
            line_len[l] = len;
            for (int j = 0; j < len; j++) line_byte[l][j] = 8'(base + 16 * l + j);
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        cam_dat = b;
        repeat (4) @(negedge clk);
        cam_xclk = 1'b1;
        repeat (4) @(negedge clk);
        cam_xclk = 1'b0;
    endtask

    task automatic send_line(input int l);
        cam_href = 1'b1;
        repeat (4) @(negedge clk);
        for (int j = 0; j < line_len[l]; j++) send_byte(line_byte[l][j]);
        repeat (4) @(negedge clk);
        cam_href = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_frame(input int nlines, input bit expect_fd);
        int fd_before;
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (8) @(negedge clk);
        for (int l = 0; l < nlines; l++) send_line(l);
        fd_before = fd_count;
        cam_vsync = 1'b1;
        if (expect_fd) begin
            for (int i = 0; i < 40 && fd_count == fd_before; i++) @(negedge clk);
            check("frame_done", 64'(fd_count - fd_before), 64'd1);
        end else begin
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && m_valid; i++) @(negedge clk);
        check("drain", 64'(m_valid), 64'd0);
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check(tag, 64'(rx_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   nl;
        int   valid_before;

        tests = 0; fails = 0; fd_count = 0; fd_lines = 0; valid_cycles = 0;
        have_prev = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_word = '0;
        resetn = 1'b0; cam_xclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0;
        cam_dat = 8'd0; enable = 1'b0; ready_ctl = 1'b1; rand_mode = 1'b0;
        clear_status = 1'b0;

        vecs[0] = '{nlines: 1, len: 6,  base: 'h00, exp_words: 1, exp_mis: 1'b1};
        vecs[1] = '{nlines: 1, len: 4,  base: 'h20, exp_words: 1, exp_mis: 1'b0};
        vecs[2] = '{nlines: 3, len: 8,  base: 'h40, exp_words: 6, exp_mis: 1'b0};
        vecs[3] = '{nlines: 2, len: 3,  base: 'h80, exp_words: 0, exp_mis: 1'b1};
        vecs[4] = '{nlines: 2, len: 13, base: 'hA0, exp_words: 6, exp_mis: 1'b1};
        vecs[5] = '{nlines: 1, len: 1,  base: 'hC0, exp_words: 0, exp_mis: 1'b1};

        // Reset for one clock edge
        @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_sof", 64'(m_sof), 64'd0);
        check("rst_m_eol", 64'(m_eol), 64'd0);
        check("rst_line_count", 64'(line_count), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);

        // Normal frame with two 8-byte lines
        fill_lines(2, 8, 'h00);
        rx_q.delete();
        exp_q.delete();
        exp_q.push_back('{data: 32'h03020100, sof: 1'b1, eol: 1'b0});
        exp_q.push_back('{data: 32'h07060504, sof: 1'b0, eol: 1'b1});
        exp_q.push_back('{data: 32'h13121110, sof: 1'b0, eol: 1'b0});
        exp_q.push_back('{data: 32'h17161514, sof: 1'b0, eol: 1'b1});
        run_frame(2, 1'b1);
        check("normal_lines", 64'(fd_lines), 64'd2);
        wait_drain();
        compare_q("normal_word");
        check("normal_overflow", 64'(overflow), 64'd0);
        check("normal_misalign", 64'(misalign), 64'd0);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            pulse_clear();
            fill_lines(vecs[v].nlines, vecs[v].len, vecs[v].base);
            model_frame(vecs[v].nlines);
            rx_q.delete();
            run_frame(vecs[v].nlines, 1'b1);
            wait_drain();
            check("vec_words", 64'(rx_q.size()), 64'(vecs[v].exp_words));
            check("vec_misalign", 64'(misalign), 64'(vecs[v].exp_mis));
            check("vec_lines", 64'(fd_lines), 64'(vecs[v].nlines));
            compare_q("vec_word");
        end

        // Randomized frames with random backpressure
        for (int f = 0; f < 8; f++) begin
            pulse_clear();
            nl = int'($urandom_range(1, 3));
            for (int l = 0; l < nl; l++) begin
                line_len[l] = int'($urandom_range(1, 14));
                for (int j = 0; j < line_len[l]; j++) line_byte[l][j] = 8'($urandom_range(0, 255));
            end
            model_frame(nl);
            rx_q.delete();
            rand_mode = 1'b1;
            run_frame(nl, 1'b1);
            check("rand_lines", 64'(fd_lines), 64'(nl));
            wait_drain();
            rand_mode = 1'b0;
            compare_q("rand_word");
            check("rand_misalign", 64'(misalign), 64'(exp_mis));
            check("rand_overflow", 64'(overflow), 64'd0);
        end

        // Backpressure: 32-byte line with the sink stalled
        pulse_clear();
        ready_ctl = 1'b0;
        fill_lines(1, 32, 'h00);
        rx_q.delete();
        run_frame(1, 1'b1);
        repeat (4) @(negedge clk);
        check("bp_overflow", 64'(overflow), 64'd1);
        check("bp_valid", 64'(m_valid), 64'd1);
        check("bp_misalign", 64'(misalign), 64'd0);
        pulse_clear();
        check("bp_overflow_cleared", 64'(overflow), 64'd0);
        check("bp_valid_kept", 64'(m_valid), 64'd1);
        exp_q.delete();
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{data: {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, sof: (k == 0), eol: 1'b0});
        ready_ctl = 1'b1;
        wait_drain();
        compare_q("bp_word");

        // Enable dropped mid-frame: frame still completes
        fill_lines(2, 8, 'h30);
        model_frame(2);
        rx_q.delete();
        fork
            run_frame(2, 1'b1);
            begin
                for (int i = 0; i < 200 && !cam_href; i++) @(negedge clk);
                repeat (6) @(negedge clk);
                enable = 1'b0;
            end
        join
        wait_drain();
        compare_q("endrop_word");

        // Late enable: rising while href is high must not start a capture
        fill_lines(1, 8, 'h70);
        rx_q.delete();
        valid_before = valid_cycles;
        fork
            run_frame(1, 1'b0);
            begin
                for (int i = 0; i < 200 && !cam_href; i++) @(negedge clk);
                repeat (10) @(negedge clk);
                enable = 1'b1;
            end
        join
        check("late_no_valid", 64'(valid_cycles - valid_before), 64'd0);
        check("late_no_words", 64'(rx_q.size()), 64'd0);
        fill_lines(1, 8, 'h90);
        model_frame(1);
        rx_q.delete();
        run_frame(1, 1'b1);
        wait_drain();
        compare_q("late_word");

        // Mid-line reset after a misaligned frame left status set
        pulse_clear();
        fill_lines(1, 5, 'h50);
        rx_q.delete();
        run_frame(1, 1'b1);
        wait_drain();
        check("pre_rst_misalign", 64'(misalign), 64'd1);
        rx_q.delete();
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (8) @(negedge clk);
        cam_href = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'hE0);
        send_byte(8'hE1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        send_byte(8'hE2);
        send_byte(8'hE3);
        repeat (4) @(negedge clk);
        cam_href = 1'b0;
        repeat (8) @(negedge clk);
        cam_vsync = 1'b1;
        repeat (12) @(negedge clk);
        check("mrst_words", 64'(rx_q.size()), 64'd0);
        check("mrst_valid", 64'(m_valid), 64'd0);
        check("mrst_misalign", 64'(misalign), 64'd0);
        check("mrst_overflow", 64'(overflow), 64'd0);
        check("mrst_line_count", 64'(line_count), 64'd0);

        // Capture resumes on the next frame
        fill_lines(1, 4, 'hF0);
        model_frame(1);
        rx_q.delete();
        run_frame(1, 1'b1);
        wait_drain();
        compare_q("resume_word");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
